// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the arbiter FSM state encoding, the grant-id width helper and
// the offset helper used to pick one requester's word out of the packed
// data bus.
package fifo_arb_pkg;

   // Largest requester count the arbiter is meant to be built with.
   localparam int N_REQ_MAX = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Low bit of requester idx's word inside the packed data bus.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/write_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans the request vector starting one past the previous winner and
// wrapping around, returning the first set bit and whether one was found.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   output logic             found,
   output logic [ID_W-1:0]  winner
);

   logic [ID_W-1:0] cand;

   // Walk the candidates in priority order; the first valid one wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ID_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/write_port_arbiter.sv
// Write-port arbiter in front of the async FIFO write side.
// Grants one requester at a time in round-robin order and forwards its
// beats as FIFO writes; the FIFO full flag is the only backpressure.
// Optional build macro WARB_PKT_LOCK_EN: when defined the grant is held
// for a whole packet and released on the accepted req_last beat; when
// undefined req_last is ignored and the grant releases after every
// accepted beat. Either way a released grant spends one cycle in IDLE.
module write_port_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int DATA_W = 8,
   localparam int ID_W   = id_width(N_REQ)
) (
   input  logic                      w_clk,
   input  logic                      w_rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_w_en,
   output logic [DATA_W-1:0]         fifo_w_data,
   output logic                      grant_active,
   output logic [ID_W-1:0]           grant_id
);

   arb_state_t      state;
   logic [ID_W-1:0] last_grant;
   logic            pick_found;
   logic [ID_W-1:0] pick_winner;
   logic            accept;
   logic            release_grant;

   rr_pick #(
      .N_REQ(N_REQ)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .found      (pick_found),
      .winner     (pick_winner)
   );

   assign accept    = grant_active & req_valid[grant_id] & ~fifo_full;
   assign fifo_w_en = accept;

`ifdef WARB_PKT_LOCK_EN
   assign release_grant = accept & req_last[grant_id];
`else
   logic unused_last;
   assign unused_last   = ^req_last;
   assign release_grant = accept;
`endif

   // Only the granted requester sees ready, and only while the FIFO has room.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant_active & (grant_id == ID_W'(i)) & ~fifo_full;
      end
   end

   // Steer the granted requester's word onto the FIFO bus; zero when idle.
   always_comb begin
      fifo_w_data = '0;
      if (grant_active) begin
         fifo_w_data = req_data[slice_lo(int'(grant_id), DATA_W) +: DATA_W];
      end
   end

   // Arbiter FSM: pick a winner in IDLE, hold it in GRANT until released.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         state        <= IDLE;
         grant_active <= 1'b0;
         grant_id     <= '0;
         last_grant   <= ID_W'(N_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state        <= GRANT;
                  grant_active <= 1'b1;
                  grant_id     <= pick_winner;
                  last_grant   <= pick_winner;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  state        <= IDLE;
                  grant_active <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               grant_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed self-checking bench for write_port_arbiter (N_REQ=4, DATA_W=8).
// Expectations follow the build: packet-locked grants when
// WARB_PKT_LOCK_EN is defined, per-beat round-robin otherwise.
module tb_write_port_arbiter;

   logic        w_clk = 1'b0;
   logic        w_rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_w_en;
   logic [7:0]  fifo_w_data;
   logic        grant_active;
   logic [1:0]  grant_id;

   int checkCount = 0;
   int errorCount = 0;

   localparam logic [31:0] BASE = 32'hD0C0B0A0;

   write_port_arbiter #(
      .N_REQ  (4),
      .DATA_W (8)
   ) dut (
      .w_clk        (w_clk),
      .w_rst        (w_rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_w_en    (fifo_w_en),
      .fifo_w_data  (fifo_w_data),
      .grant_active (grant_active),
      .grant_id     (grant_id)
   );

   always #5 w_clk = ~w_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic full, input logic [31:0] data);
      req_valid = valid;
      req_last  = last;
      fifo_full = full;
      req_data  = data;
   endtask

   // Check outputs at the falling edge, then step to just after the next rising edge.
   task automatic cycleCheck(input string tag, input logic exp_active, input logic [1:0] exp_id,
                             input logic exp_en, input logic [7:0] exp_data, input logic [3:0] exp_ready);
      @(negedge w_clk);
      checkOutput({tag, ".active"}, 32'(grant_active), 32'(exp_active));
      if (exp_active) checkOutput({tag, ".id"}, 32'(grant_id), 32'(exp_id));
      checkOutput({tag, ".en"},    32'(fifo_w_en),   32'(exp_en));
      checkOutput({tag, ".data"},  32'(fifo_w_data), 32'(exp_data));
      checkOutput({tag, ".ready"}, 32'(req_ready),   32'(exp_ready));
      @(posedge w_clk);
      #1;
   endtask

   task automatic doReset();
      w_rst = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
      repeat (2) @(posedge w_clk);
      #1;
      w_rst = 1'b0;
   endtask

   initial begin
      // Reset values, with every requester asking so a grant would be visible.
      w_rst = 1'b1;
      applyStimulus(4'b1111, 4'b0000, 1'b0, BASE);
      @(posedge w_clk);
      cycleCheck("rst", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      checkOutput("rst.id", 32'(grant_id), 32'd0);

      // Single requester 0, three beats 0x11, 0x12, 0x13.
      doReset();
      applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h11);
      cycleCheck("t1.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t1.b0",  1'b1, 2'd0, 1'b1, 8'h11, 4'b0001);
`ifdef WARB_PKT_LOCK_EN
      applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h12);
      cycleCheck("t1.b1",  1'b1, 2'd0, 1'b1, 8'h12, 4'b0001);
      applyStimulus(4'b0001, 4'b0001, 1'b0, 32'h13);
      cycleCheck("t1.b2",  1'b1, 2'd0, 1'b1, 8'h13, 4'b0001);
`else
      applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h12);
      cycleCheck("t1.gap0", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t1.b1",   1'b1, 2'd0, 1'b1, 8'h12, 4'b0001);
      applyStimulus(4'b0001, 4'b0001, 1'b0, 32'h13);
      cycleCheck("t1.gap1", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t1.b2",   1'b1, 2'd0, 1'b1, 8'h13, 4'b0001);
`endif
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
      cycleCheck("t1.end",  1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t1.stay", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

      // Round robin across requesters.
      doReset();
`ifdef WARB_PKT_LOCK_EN
      for (int r = 0; r < 4; r++) begin
         logic [3:0] mask;
         mask = 4'(4'b1111 << r);
         applyStimulus(mask, 4'b0000, 1'b0, BASE);
         cycleCheck("t2.gap", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
         cycleCheck("t2.b0", 1'b1, 2'(r), 1'b1, 8'(32'hA0 + 32'h10 * r), 4'(1 << r));
         applyStimulus(mask, 4'(1 << r), 1'b0, BASE | (32'h1 << (8 * r)));
         cycleCheck("t2.b1", 1'b1, 2'(r), 1'b1, 8'(32'hA1 + 32'h10 * r), 4'(1 << r));
      end
`else
      applyStimulus(4'b0011, 4'b0000, 1'b0, 32'h0000B0A0);
      cycleCheck("t2.gap0", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t2.a0",   1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      applyStimulus(4'b0011, 4'b0001, 1'b0, 32'h0000B0A1);
      cycleCheck("t2.gap1", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t2.b0",   1'b1, 2'd1, 1'b1, 8'hB0, 4'b0010);
      applyStimulus(4'b0011, 4'b0011, 1'b0, 32'h0000B1A1);
      cycleCheck("t2.gap2", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t2.a1",   1'b1, 2'd0, 1'b1, 8'hA1, 4'b0001);
      applyStimulus(4'b0010, 4'b0010, 1'b0, 32'h0000B100);
      cycleCheck("t2.gap3", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t2.b1",   1'b1, 2'd1, 1'b1, 8'hB1, 4'b0010);
`endif
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
      cycleCheck("t2.end", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

      // FIFO full for five cycles while requester 2 holds the grant.
      doReset();
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h00310000);
      cycleCheck("t3.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t3.b0",  1'b1, 2'd2, 1'b1, 8'h31, 4'b0100);
`ifndef WARB_PKT_LOCK_EN
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h00320000);
      cycleCheck("t3.gap0", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
`endif
      applyStimulus(4'b0100, 4'b0000, 1'b1, 32'h00320000);
      for (int s = 0; s < 5; s++) begin
         cycleCheck("t3.stall", 1'b1, 2'd2, 1'b0, 8'h32, 4'b0000);
      end
      applyStimulus(4'b0100, 4'b0000, 1'b0, 32'h00320000);
      cycleCheck("t3.b1", 1'b1, 2'd2, 1'b1, 8'h32, 4'b0100);
`ifndef WARB_PKT_LOCK_EN
      applyStimulus(4'b0100, 4'b0100, 1'b0, 32'h00330000);
      cycleCheck("t3.gap1", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
`endif
      applyStimulus(4'b0100, 4'b0100, 1'b0, 32'h00330000);
      cycleCheck("t3.b2", 1'b1, 2'd2, 1'b1, 8'h33, 4'b0100);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
      cycleCheck("t3.end", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

`ifdef WARB_PKT_LOCK_EN
      // Requester 1 pauses mid-packet while requester 3 waits.
      doReset();
      applyStimulus(4'b1010, 4'b1000, 1'b0, 32'h61004100);
      cycleCheck("t4.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t4.b0",  1'b1, 2'd1, 1'b1, 8'h41, 4'b0010);
      applyStimulus(4'b1000, 4'b1000, 1'b0, 32'h61004200);
      for (int s = 0; s < 3; s++) begin
         cycleCheck("t4.pause", 1'b1, 2'd1, 1'b0, 8'h42, 4'b0010);
      end
      applyStimulus(4'b1010, 4'b1010, 1'b0, 32'h61004200);
      cycleCheck("t4.b1",  1'b1, 2'd1, 1'b1, 8'h42, 4'b0010);
      applyStimulus(4'b1000, 4'b1000, 1'b0, 32'h61000000);
      cycleCheck("t4.gap", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t4.r3",  1'b1, 2'd3, 1'b1, 8'h61, 4'b1000);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
      cycleCheck("t4.end", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
`endif

      // Reset while a grant is held, then restart with everyone valid.
      doReset();
      applyStimulus(4'b1111, 4'b0000, 1'b0, BASE);
      cycleCheck("t5.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t5.b0",  1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
`ifndef WARB_PKT_LOCK_EN
      cycleCheck("t5.gap", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
`endif
      w_rst = 1'b1;
      cycleCheck("t5.rst", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      checkOutput("t5.rst.id", 32'(grant_id), 32'd0);
      w_rst = 1'b0;
      cycleCheck("t5.idle",    1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      cycleCheck("t5.regrant", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/write_port_arbiter.md
# write_port_arbiter

Shares the single write port of the async FIFO write domain among N_REQ requesters in the w_clk domain. It grants one requester at a time in round-robin order. It holds the grant for a whole packet and forwards that requester's beats as FIFO write enables. The FIFO full flag is the only backpressure source. The block sits directly in front of the FIFO write side: its fifo_w_en feeds the FIFO write enable, and its fifo_full input is taken from the FIFO's full flag.

## Interface
- N_REQ, 4: number of requesters, 2..16
- DATA_W, 8: FIFO word width
- w_clk  in  1  write-domain clock
- w_rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester beat valid
- req_data  in  N_REQ*DATA_W  per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  marks the final beat of a packet
- req_ready  out  N_REQ  per-requester beat accepted
- fifo_full  in  1  FIFO full flag
- fifo_w_en  out  1  FIFO write enable
- fifo_w_data  out  DATA_W  FIFO write data
- grant_active  out  1  a grant is currently held
- grant_id  out  $clog2(N_REQ)  index of the granted requester

## Operation
- FSM states:
  - IDLE: no grant held.
  - GRANT: grant_active=1, grant_id valid.
- IDLE → GRANT:
  - Taken when any req_valid is 1.
  - The winner is the first valid requester scanning from (last_grant+1) mod N_REQ upward, with wrap-around.
  - grant_id and last_grant are registered with the winner.
- IDLE with no valid requester: stay in IDLE; last_grant is unchanged.
- Beat acceptance, all combinational from registered state:
  - accept = grant_active & req_valid[grant_id] & ~fifo_full
  - fifo_w_en = accept
  - req_ready[i] = grant_active & (i==grant_id) & ~fifo_full; 0 for all non-granted requesters
  - fifo_w_data = req_data slice of grant_id whenever grant_active=1; otherwise 0
- GRANT → IDLE: taken on the cycle where accept & req_last[grant_id]=1.
- Otherwise GRANT is held.
- fifo_full=1 mid-packet: grant is held, no write occurs, req_ready=0. Transfer resumes on the first cycle fifo_full=0.
- Granted requester deasserts req_valid mid-packet: grant is held indefinitely. No timeout; the requester must complete the packet.
- Non-granted requester valids: ignored while in GRANT. Their data is never forwarded.
- Reset mid-packet: the packet is aborted. The requester must restart the packet after reset.

## Timing
- Reset values:
  - state=IDLE, grant_active=0, grant_id=0
  - last_grant=N_REQ-1, so the first grant goes to requester 0
  - req_ready=0, fifo_w_en=0, fifo_w_data=0
- Arbitration latency: a requester valid in IDLE at edge k is granted after edge k. Its first beat can be written at edge k+1.
- Back-to-back beats within a packet: one beat per cycle, provided fifo_full=0.
- Packet turnaround: the last beat is accepted at edge k. The FSM is in IDLE for one cycle and the next grant registers at edge k+1. Consecutive packets therefore have a 1-cycle bubble, even from the same requester.
- No combinational path from req_valid to req_ready. A path from fifo_full to req_ready/fifo_w_en is permitted; the full flag is registered inside the FIFO.

## Configuration
- WARB_PKT_LOCK_EN:
  - Defined: packet-locked grant as described in Operation; the grant releases only on an accepted last beat.
  - Undefined: req_last is ignored and the grant releases after every accepted beat, giving per-beat round-robin interleaving.
  - All other timing is identical in both modes, including the 1-cycle IDLE bubble.

## Structure
- Package fifo_arb_pkg holds:
  - the FSM state enum (IDLE, GRANT)
  - a width helper for the grant id
  - a function for the packed-data slice offset
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: found, winner index.
  - Instantiated once.

## Test plan
- Reset, then req_valid=4'b0001 with a 3-beat packet, data 0x11,0x12,0x13 (last on 0x13) → grant_id=0 one cycle later; fifo_w_en high for 3 consecutive cycles with data 0x11,0x12,0x13; grant_active=0 on the next cycle.
- All four requesters valid, each with a 2-beat packet → grants in order 0,1,2,3; each packet written contiguously; 1 idle cycle between packets.
- fifo_full asserted for 5 cycles mid-packet on requester 2 → fifo_w_en=0 and req_ready=0 during the stall; grant_id stays 2; remaining beats follow with no loss or duplication.
- Requester 1 granted, drops req_valid for 3 cycles, requester 3 valid throughout → grant stays on 1; requester 3 is granted only after requester 1's last beat.
- Assert w_rst mid-packet → all outputs return to their reset values; after release with all requesters valid, the first grant goes to requester 0.
- WARB_PKT_LOCK_EN undefined, requesters 0 and 1 valid with 2-beat packets → FIFO receives 0-beat0, 1-beat0, 0-beat1, 1-beat1, with one idle cycle between beats.
